// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: load marker, forwarding selects
// and the mul/div occupancy FSM states.
package hazard_pkg;

   localparam logic [1:0] RES_MEM = 2'b01;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_W   = 2'b01;
   localparam logic [1:0] FWD_M   = 2'b10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_ctrl_md_occupancy.sv
// Tracks how long a multi-cycle mul/div op keeps Execute occupied; freezes while the
// memory port holds the pipeline.
module md_occupancy
   import hazard_pkg::*;
#(
   parameter int MD_LAT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic hold,
   output logic stall,
   output logic done,
   output logic busy
);

   localparam int CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (MD_LAT > 1) ? CNT_W'(MD_LAT - 2) : '0;

   md_state_t        state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // The op already sits in E during the cnt==0 cycle, so a still-high start must not relaunch.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      if (!hold) begin
         unique case (state)
            MD_IDLE: begin
               if (start && (MD_LAT > 1)) begin
                  stateNext = MD_BUSY;
                  cntNext   = CNT_INIT;
               end
            end
            MD_BUSY: begin
               if (cnt == '0) begin
                  stateNext = MD_IDLE;
               end else begin
                  cntNext = cnt - CNT_W'(1);
               end
            end
            default: begin
               stateNext = MD_IDLE;
               cntNext   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall = 1'b0;
      done  = 1'b0;
      busy  = 1'b0;
      unique case (state)
         MD_IDLE: begin
            stall = start && (MD_LAT > 1);
            done  = start && (MD_LAT == 1);
         end
         MD_BUSY: begin
            busy  = 1'b1;
            stall = (cnt != '0);
            done  = (cnt == '0);
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: forwarding, load-use/RAW stalls,
// mul/div occupancy, branch flushes and the memory-wait freeze.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MD_LAT = 4,
   parameter int FWD_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic [REG_AW-1:0] Rs1E,
   input  logic [REG_AW-1:0] Rs2E,
   input  logic [REG_AW-1:0] RdE,
   input  logic [REG_AW-1:0] RdM,
   input  logic [REG_AW-1:0] RdW,
   input  logic              RegWriteE,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic [1:0]        ResultSrcE,
   input  logic              MdStartE,
   input  logic              PCSrcE,
   input  logic              MemReadyM,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              StallM,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              FlushW,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              MdBusy,
   output logic              MdDoneE
);

   logic luHazard;
   logic rawHazard;
   logic mdStall;
   logic mdDone;
   logic mdBusyRaw;

   function automatic logic [1:0] fwdSelect(
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] rdM,
      input logic              wrM,
      input logic [REG_AW-1:0] rdW,
      input logic              wrW
   );
      if ((src != '0) && (src == rdM) && wrM) begin
         return FWD_M;
      end else if ((src != '0) && (src == rdW) && wrW) begin
         return FWD_W;
      end
      return FWD_RF;
   endfunction

   function automatic logic rawMatch(
      input logic [REG_AW-1:0] src,
      input logic [REG_AW-1:0] rd,
      input logic              wr
   );
      return (src != '0) && (src == rd) && wr;
   endfunction

   // A branch sharing the E slot with a mul/div op squashes it, so the FSM never starts.
   md_occupancy #(
      .MD_LAT (MD_LAT)
   ) mdOcc (
      .clk   (clk),
      .rst_n (rst_n),
      .start (MdStartE && !PCSrcE),
      .hold  (!MemReadyM),
      .stall (mdStall),
      .done  (mdDone),
      .busy  (mdBusyRaw)
   );

   always_comb begin
      luHazard  = 1'b0;
      rawHazard = 1'b0;
      if (FWD_EN != 0) begin
         luHazard = (ResultSrcE == RES_MEM) && (RdE != '0) &&
                    ((Rs1D == RdE) || (Rs2D == RdE));
      end else begin
         rawHazard = rawMatch(Rs1D, RdE, RegWriteE) || rawMatch(Rs2D, RdE, RegWriteE) ||
                     rawMatch(Rs1D, RdM, RegWriteM) || rawMatch(Rs2D, RdM, RegWriteM) ||
                     rawMatch(Rs1D, RdW, RegWriteW) || rawMatch(Rs2D, RdW, RegWriteW);
      end
   end

   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (rst_n && (FWD_EN != 0)) begin
         ForwardAE = fwdSelect(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
         ForwardBE = fwdSelect(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      end
   end

   // Priority chain: a frozen pipeline defers every other request until memory is ready.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b0;
      FlushW = 1'b0;
      if (!rst_n) begin
         StallF = 1'b0;
      end else if (!MemReadyM) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (mdStall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         FlushM = 1'b1;
      end else if (luHazard || rawHazard) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   assign MdBusy  = rst_n && mdBusyRaw;
   assign MdDoneE = rst_n && mdDone;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default build, a single-cycle mul/div build and a
// no-forwarding build all share one stimulus sequence.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       RegWriteE, RegWriteM, RegWriteW;
   logic [1:0] ResultSrcE;
   logic       MdStartE, PCSrcE, MemReadyM;

   wire [3:0] stallMain, flushMain, stallLat1, flushLat1, stallNoFwd, flushNoFwd;
   wire [1:0] fwdAMain, fwdBMain, fwdALat1, fwdBLat1, fwdANoFwd, fwdBNoFwd;
   wire       busyMain, doneMain, busyLat1, doneLat1, busyNoFwd, doneNoFwd;

   int compared   = 0;
   int mismatched = 0;

   hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .FWD_EN(1)) dutMain (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
      .MemReadyM(MemReadyM),
      .StallF(stallMain[3]), .StallD(stallMain[2]), .StallE(stallMain[1]), .StallM(stallMain[0]),
      .FlushD(flushMain[3]), .FlushE(flushMain[2]), .FlushM(flushMain[1]), .FlushW(flushMain[0]),
      .ForwardAE(fwdAMain), .ForwardBE(fwdBMain), .MdBusy(busyMain), .MdDoneE(doneMain)
   );

   hazard_ctrl #(.REG_AW(5), .MD_LAT(1), .FWD_EN(1)) dutLat1 (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
      .MemReadyM(MemReadyM),
      .StallF(stallLat1[3]), .StallD(stallLat1[2]), .StallE(stallLat1[1]), .StallM(stallLat1[0]),
      .FlushD(flushLat1[3]), .FlushE(flushLat1[2]), .FlushM(flushLat1[1]), .FlushW(flushLat1[0]),
      .ForwardAE(fwdALat1), .ForwardBE(fwdBLat1), .MdBusy(busyLat1), .MdDoneE(doneLat1)
   );

   hazard_ctrl #(.REG_AW(5), .MD_LAT(4), .FWD_EN(0)) dutNoFwd (
      .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .MdStartE(MdStartE), .PCSrcE(PCSrcE),
      .MemReadyM(MemReadyM),
      .StallF(stallNoFwd[3]), .StallD(stallNoFwd[2]), .StallE(stallNoFwd[1]), .StallM(stallNoFwd[0]),
      .FlushD(flushNoFwd[3]), .FlushE(flushNoFwd[2]), .FlushM(flushNoFwd[1]), .FlushW(flushNoFwd[0]),
      .ForwardAE(fwdANoFwd), .ForwardBE(fwdBNoFwd), .MdBusy(busyNoFwd), .MdDoneE(doneNoFwd)
   );

   // Stall vectors are {F,D,E,M}; flush vectors are {D,E,M,W}.
   task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(negedge clk);
   endtask

   task automatic idleInputs();
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
      RdE = '0; RdM = '0; RdW = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      ResultSrcE = 2'b00; MdStartE = 1'b0; PCSrcE = 1'b0; MemReadyM = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      idleInputs();

      applyStimulus();
      MemReadyM = 1'b0; PCSrcE = 1'b1; Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; MdStartE = 1'b1;
      #1;
      checkOutput("resetStall", stallMain, 4'b0000);
      checkOutput("resetFlush", flushMain, 4'b0000);
      checkOutput("resetFwdA", {2'b00, fwdAMain}, {2'b00, FWD_RF});

      applyStimulus();
      rst_n = 1'b1;
      idleInputs();
      #1;
      checkOutput("idleBusy", {3'b000, busyMain}, 4'b0000);

      applyStimulus();
      Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1;
      #1;
      checkOutput("fwdAPriorityM", {2'b00, fwdAMain}, 4'b0010);
      checkOutput("fwdTiedNoFwd", {2'b00, fwdANoFwd}, 4'b0000);
      applyStimulus();
      RdM = 5'd0;
      #1;
      checkOutput("fwdAFromW", {2'b00, fwdAMain}, 4'b0001);
      applyStimulus();
      Rs1E = 5'd0;
      #1;
      checkOutput("fwdAZeroReg", {2'b00, fwdAMain}, 4'b0000);
      applyStimulus();
      Rs2E = 5'd9; RdM = 5'd9; RegWriteM = 1'b0; RdW = 5'd9; RegWriteW = 1'b1;
      #1;
      checkOutput("fwdBWriteGateM", {2'b00, fwdBMain}, 4'b0001);
      checkOutput("fwdNoStall", stallMain, 4'b0000);

      applyStimulus();
      idleInputs();
      ResultSrcE = RES_MEM; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      checkOutput("luStall", stallMain, 4'b1100);
      checkOutput("luFlush", flushMain, 4'b0100);
      applyStimulus();
      ResultSrcE = 2'b00; RdE = 5'd0;
      #1;
      checkOutput("luOneBubble", stallMain, 4'b0000);
      applyStimulus();
      ResultSrcE = RES_MEM; RdE = 5'd0; Rs2D = 5'd0;
      #1;
      checkOutput("luZeroRd", stallMain, 4'b0000);
      applyStimulus();
      ResultSrcE = 2'b10; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      checkOutput("luNotLoad", stallMain, 4'b0000);

      applyStimulus();
      idleInputs();
      MdStartE = 1'b1;
      #1;
      checkOutput("mdT0Stall", stallMain, 4'b1110);
      checkOutput("mdT0Flush", flushMain, 4'b0010);
      checkOutput("mdT0Busy", {3'b000, busyMain}, 4'b0000);
      checkOutput("lat1Stall", stallLat1, 4'b0000);
      checkOutput("lat1Done", {3'b000, doneLat1}, 4'b0001);
      applyStimulus();
      #1;
      checkOutput("mdT1Stall", stallMain, 4'b1110);
      checkOutput("mdT1Busy", {3'b000, busyMain}, 4'b0001);
      checkOutput("mdT1Done", {3'b000, doneMain}, 4'b0000);
      checkOutput("lat1NeverBusy", {3'b000, busyLat1}, 4'b0000);
      applyStimulus();
      #1;
      checkOutput("mdT2Stall", stallMain, 4'b1110);
      applyStimulus();
      #1;
      checkOutput("mdT3Stall", stallMain, 4'b0000);
      checkOutput("mdT3Done", {3'b000, doneMain}, 4'b0001);
      checkOutput("mdT3Busy", {3'b000, busyMain}, 4'b0001);
      applyStimulus();
      MdStartE = 1'b0;
      #1;
      checkOutput("mdNoRetrigger", {3'b000, busyMain}, 4'b0000);
      checkOutput("mdT4Done", {3'b000, doneMain}, 4'b0000);

      applyStimulus();
      MdStartE = 1'b1;
      #1;
      checkOutput("mwT0Stall", stallMain, 4'b1110);
      applyStimulus();
      MemReadyM = 1'b0;
      #1;
      checkOutput("mwT1Stall", stallMain, 4'b1111);
      checkOutput("mwT1Flush", flushMain, 4'b0001);
      applyStimulus();
      #1;
      checkOutput("mwT2Stall", stallMain, 4'b1111);
      applyStimulus();
      MemReadyM = 1'b1;
      #1;
      checkOutput("mwT3Stall", stallMain, 4'b1110);
      checkOutput("mwT3Done", {3'b000, doneMain}, 4'b0000);
      applyStimulus();
      #1;
      checkOutput("mwT4Stall", stallMain, 4'b1110);
      checkOutput("mwT4Done", {3'b000, doneMain}, 4'b0000);
      applyStimulus();
      #1;
      checkOutput("mwT5Done", {3'b000, doneMain}, 4'b0001);
      checkOutput("mwT5Stall", stallMain, 4'b0000);
      applyStimulus();
      MdStartE = 1'b0;
      #1;
      checkOutput("mwIdle", {3'b000, busyMain}, 4'b0000);

      applyStimulus();
      PCSrcE = 1'b1; ResultSrcE = RES_MEM; RdE = 5'd7; Rs1D = 5'd7;
      #1;
      checkOutput("ctlStall", stallMain, 4'b0000);
      checkOutput("ctlFlush", flushMain, 4'b1100);
      applyStimulus();
      MemReadyM = 1'b0;
      #1;
      checkOutput("ctlWaitStall", stallMain, 4'b1111);
      checkOutput("ctlWaitFlush", flushMain, 4'b0001);
      applyStimulus();
      MemReadyM = 1'b1;
      #1;
      checkOutput("ctlAfterWait", flushMain, 4'b1100);
      checkOutput("ctlAfterWaitSt", stallMain, 4'b0000);

      applyStimulus();
      idleInputs();
      PCSrcE = 1'b1; MdStartE = 1'b1;
      #1;
      checkOutput("ctlVsMdStall", stallMain, 4'b0000);
      checkOutput("ctlVsMdFlush", flushMain, 4'b1100);
      applyStimulus();
      idleInputs();
      #1;
      checkOutput("ctlVsMdNoBusy", {3'b000, busyMain}, 4'b0000);

      applyStimulus();
      MdStartE = 1'b1;
      #1;
      checkOutput("rstT0Stall", stallMain, 4'b1110);
      applyStimulus();
      rst_n = 1'b0;
      #1;
      checkOutput("rstMidStall", stallMain, 4'b0000);
      checkOutput("rstMidBusy", {3'b000, busyMain}, 4'b0000);
      applyStimulus();
      rst_n = 1'b1; MdStartE = 1'b0;
      #1;
      checkOutput("rstAfterBusy", {3'b000, busyMain}, 4'b0000);
      checkOutput("rstAfterStall", stallMain, 4'b0000);

      applyStimulus();
      idleInputs();
      Rs1D = 5'd3; RdW = 5'd3; RegWriteW = 1'b1;
      #1;
      checkOutput("rawWStall", stallNoFwd, 4'b1100);
      checkOutput("rawWFlush", flushNoFwd, 4'b0100);
      checkOutput("rawFwdBuild", stallMain, 4'b0000);
      applyStimulus();
      RdW = 5'd0; RegWriteW = 1'b0;
      #1;
      checkOutput("rawWCleared", stallNoFwd, 4'b0000);
      applyStimulus();
      idleInputs();
      Rs2D = 5'd4; RdE = 5'd4; RegWriteE = 1'b1;
      #1;
      checkOutput("rawEStall", stallNoFwd, 4'b1100);
      applyStimulus();
      RegWriteE = 1'b0;
      #1;
      checkOutput("rawENoWrite", stallNoFwd, 4'b0000);
      applyStimulus();
      idleInputs();
      Rs1D = 5'd0; RdM = 5'd0; RegWriteM = 1'b1;
      #1;
      checkOutput("rawZeroReg", stallNoFwd, 4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage (F/D/E/M/W) RISC-V core. It resolves four kinds of hazard:
- RAW hazards, by forwarding or, optionally, by stalling.
- Load-use hazards.
- Multi-cycle multiply/divide occupancy of Execute, tracked with an internal FSM and counter.
- Control hazards from branches and jumps resolved in Execute.

It also freezes the whole pipeline while the data-memory port is not ready. It produces per-stage stall and flush enables plus the E-stage forwarding selects for the datapath's pipeline registers and ALU operand muxes.

## Interface
Parameters:
- `REG_AW`, default 5: register-address width.
- `MD_LAT`, default 4: Execute occupancy of a mul/div op, in cycles. Must be ≥1.
- `FWD_EN`, default 1: 1 = forward from M/W; 0 = no forwarding, stall D until the producer has written back.

Ports:
- `clk`  in  1: the block's single clock.
- `rst_n`  in  1: synchronous reset, active-low.
- `Rs1D`, `Rs2D`  in  REG_AW: source registers in Decode.
- `Rs1E`, `Rs2E`, `RdE`  in  REG_AW: sources and destination in Execute.
- `RdM`, `RdW`  in  REG_AW: destinations in Memory and Writeback.
- `RegWriteE`, `RegWriteM`, `RegWriteW`  in  1: register-write enables per stage.
- `ResultSrcE`  in  2: result-source select in Execute; `RES_MEM` marks a load.
- `MdStartE`  in  1: the instruction in Execute is a mul/div op.
- `PCSrcE`  in  1: branch/jump taken, resolved in Execute.
- `MemReadyM`  in  1: data memory completes this cycle. 0 = wait.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1: hold the corresponding pipeline register.
- `FlushD`, `FlushE`, `FlushM`, `FlushW`  out  1: insert a bubble into the corresponding pipeline register.
- `ForwardAE`, `ForwardBE`  out  2: operand select. `FWD_RF`=00, `FWD_W`=01, `FWD_M`=10.
- `MdBusy`  out  1: the FSM is in `MD_BUSY`.
- `MdDoneE`  out  1: the mul/div result is valid in Execute this cycle.

## Operation
- **Forwarding (`FWD_EN`=1).** For each E source `s`:
  - `FWD_M` if `s==RdM`, `RegWriteM`, and `s!=0`.
  - Else `FWD_W` if `s==RdW`, `RegWriteW`, and `s!=0`.
  - Else `FWD_RF`.
  - M has priority over W.
- **Forwarding disabled (`FWD_EN`=0).** `ForwardAE`/`ForwardBE` are tied to `FWD_RF`.
  - `raw` = a D source (nonzero) matches `RdE`, `RdM` or `RdW` with the matching `RegWrite*` set.
  - `raw` → `StallF`, `StallD`, `FlushE`.
- **Load-use (`FWD_EN`=1).** `lu` = (`ResultSrcE==RES_MEM`) and `RdE!=0` and (`Rs1D==RdE` or `Rs2D==RdE`).
  - `lu` → `StallF`, `StallD`, `FlushE`.
- **Mul/div FSM.** States are `MD_IDLE` and `MD_BUSY`; the down-counter `cnt` is `$clog2(MD_LAT)` bits wide, minimum 1.
  - `MD_IDLE` with `MdStartE` and `MD_LAT>1`: go to `MD_BUSY` with `cnt=MD_LAT-2`, and `md_stall`=1 this cycle.
  - `MD_BUSY`: `md_stall = (cnt!=0)`. Decrement `cnt` each cycle. At `cnt==0`, `MdDoneE`=1 and the FSM returns to `MD_IDLE` at the next edge.
  - `MD_LAT==1`: the FSM never leaves `MD_IDLE`, and `MdDoneE = MdStartE`.
  - `md_stall` → `StallF`, `StallD`, `StallE`, `FlushM`.
  - `MdStartE` seen in the `cnt==0` cycle must not retrigger the FSM.
- **Control.** `PCSrcE` → `FlushD`, `FlushE`. Flush overrides a concurrent `StallD` (`StallF` stays 0 so the PC loads the target).
- **Memory wait.** `MemReadyM==0` → `StallF`, `StallD`, `StallE`, `StallM`, `FlushW`.
  - All other flushes are forced to 0.
  - The FSM and `cnt` hold their values.
  - A pending `PCSrcE`, `lu`, `raw` or `md_stall` takes effect in the first cycle with `MemReadyM=1`.
- **Priority**, highest first: memory wait, then `PCSrcE`, then `md_stall`, then `lu`/`raw`.
  - `PCSrcE` and `MdStartE` are mutually exclusive (same E slot). If both are asserted, `PCSrcE` wins and the FSM does not start.
- **Reset.** In any cycle where `rst_n` is sampled low, the FSM goes to `MD_IDLE` and `cnt` to 0, including mid-`MD_BUSY`.
  - While `rst_n==0`, all stall/flush outputs, `MdBusy` and `MdDoneE` are 0, and the forward selects are `FWD_RF`.

## Timing
- Forwarding, load-use, control and memory-wait outputs are combinational from the inputs, with zero latency.
- Mul/div outputs are combinational from the FSM state plus `MdStartE`.
- A mul/div op entering E at cycle t:
  - Stalls cycles t…t+MD_LAT-2.
  - `MdDoneE`=1 at t+MD_LAT-1.
  - Advances to M at the edge ending t+MD_LAT-1.
  - Memory-wait cycles extend this 1:1.
- A load-use hazard costs exactly one bubble. A `raw` stall (`FWD_EN`=0) lasts until the producer has left W.

## Structure
- Package `hazard_pkg`:
  - `RES_MEM` = 2'b01.
  - `FWD_RF`/`FWD_W`/`FWD_M`.
  - `md_state_t` enum.
- Sub-module `md_occupancy`: holds the FSM and `cnt`, with inputs start/hold/`rst_n` and outputs stall/done/busy.
- Forwarding and load-use/raw detection stay combinational in the top level.

## Test plan
- **Forwarding.** `Rs1E=5`, `RdM=5`, `RegWriteM=1`, `RdW=5`, `RegWriteW=1` → `ForwardAE=10`. Then `RdM=0` → `ForwardAE=01`. Then `Rs1E=0` → `ForwardAE=00`.
- **Load-use.** `ResultSrcE=01`, `RdE=7`, `Rs2D=7` → `StallF`=`StallD`=`FlushE`=1 for exactly one cycle. Repeat with `RdE=0` → no stall.
- **Mul/div, `MD_LAT=4`.** `MdStartE` at t → `StallE`=1 at t,t+1,t+2; `MdDoneE`=1 at t+3; `MdBusy`=1 at t+1…t+3. Then `MD_LAT=1` → no stall, and `MdDoneE=MdStartE`.
- **Memory wait during `MD_BUSY`.** At t+1 of a 4-cycle op, hold `MemReadyM=0` for 2 cycles → all stalls plus `FlushW` during the wait; `cnt` frozen; `MdDoneE` at t+5.
- **Control versus load-use.** `PCSrcE=1` with `lu` true → `FlushD`=`FlushE`=1, `StallF`=0. The same with `MemReadyM=0` → freeze only, and the flush is applied the cycle after ready returns.
- **Reset mid-`MD_BUSY`.** `rst_n=0` at t+1 → next cycle `MdBusy`=0, no stall. `FWD_EN=0` build: `Rs1D=3` with `RdW=3`, `RegWriteW=1` → stall until W clears.
